// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared types for the vending datapath: coin denominations, the payout FSM
// state encoding and the coin face values used by the change dispenser.
// No ports (package).
// -----------------------------------------------------------------------------
package vend_pkg;

  // Encoding matches the hopper command: 0=$1, 1=$5, 2=$10 (3 never used).
  typedef enum logic [1:0] {
    DEN_1  = 2'd0,
    DEN_5  = 2'd1,
    DEN_10 = 2'd2
  } denom_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EJECT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned VAL_1     = 1;
  localparam int unsigned VAL_5     = 5;
  localparam int unsigned VAL_10    = 10;
  localparam int unsigned NUM_DENOM = 3;

  // Face value in dollars of one coin of the given denomination.
  function automatic logic [3:0] coin_value(input denom_t d);
    case (d)
      DEN_10:  return 4'(VAL_10);
      DEN_5:   return 4'(VAL_5);
      default: return 4'(VAL_1);
    endcase
  endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// -----------------------------------------------------------------------------
// vend_change_dispenser_if
// Bundles the payout request handshake, the hopper eject handshake and the
// completion report of the change dispenser.
//   master : requester/hopper side (drives req_valid, req_amount, eject_ack)
//   slave  : dispenser side (drives req_ready, eject_valid, eject_denom,
//            done, short_amt)
// -----------------------------------------------------------------------------
interface vend_change_dispenser_if #(
  parameter int AMT_W = 8
) ();

  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             eject_valid;
  logic [1:0]       eject_denom;
  logic             eject_ack;
  logic             done;
  logic [AMT_W-1:0] short_amt;

  modport master (
    output req_valid, req_amount, eject_ack,
    input  req_ready, eject_valid, eject_denom, done, short_amt
  );

  modport slave (
    input  req_valid, req_amount, eject_ack,
    output req_ready, eject_valid, eject_denom, done, short_amt
  );

endinterface

// File: rtl/vend_change_dispenser_coin_stock_ctr.sv
// -----------------------------------------------------------------------------
// coin_stock_ctr
// Stock counter for one coin denomination. Refill adds refill_count, an
// accepted eject removes one coin; both may happen in the same cycle and the
// net result saturates at the all-ones value.
// Ports:
//   clk, rst      clock / asynchronous active-high reset (stock -> INIT_STOCK)
//   refill_en     add refill_count this cycle
//   refill_count  coins added by a refill
//   dec_en        one coin of this denomination was ejected this cycle
//   stock         current stock
// -----------------------------------------------------------------------------
module coin_stock_ctr #(
  parameter int STOCK_W    = 8,
  parameter int INIT_STOCK = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               refill_en,
  input  logic [STOCK_W-1:0] refill_count,
  input  logic               dec_en,
  output logic [STOCK_W-1:0] stock
);

  localparam logic [STOCK_W+1:0] STOCK_MAX = {2'b00, {STOCK_W{1'b1}}};

  logic [STOCK_W-1:0] stock_q, stock_d;
  // Two guard bits: one for the refill carry, one so a (never expected)
  // decrement below zero shows up as a large value rather than wrapping low.
  logic [STOCK_W+1:0] sum;

  always_comb begin
    sum = {2'b00, stock_q};
    if (refill_en) begin
      sum = sum + {2'b00, refill_count};
    end
    if (dec_en) begin
      sum = sum - (STOCK_W+2)'(1);
    end
    stock_d = (sum > STOCK_MAX) ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stock_q <= STOCK_W'(INIT_STOCK);
    end else begin
      stock_q <= stock_d;
    end
  end

  assign stock = stock_q;

endmodule

// File: rtl/vend_change_dispenser.sv
// -----------------------------------------------------------------------------
// vend_change_dispenser
// Change/refund scheduler. Accepts one payout request, then drives the coin
// hopper one coin at a time, greedy largest-first over $10/$5/$1 limited by
// the per-denomination stock, and reports any unpaid remainder.
// Ports:
//   clk, rst                  clock / asynchronous active-high reset
//   bus (slave)               req_valid/req_amount/req_ready request,
//                             eject_valid/eject_denom/eject_ack hopper command,
//                             done pulse and short_amt remainder
//   refill_valid/denom/count  add coins to a denomination's stock (any state)
//   stock1/stock5/stock10     current stock per denomination
//   paid_total                (only with CHANGE_AUDIT_EN) running total of
//                             dollars ejected, modulo 2^16
// Build option: define CHANGE_AUDIT_EN to add the paid_total audit counter.
// -----------------------------------------------------------------------------
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W      = 8,
  parameter int STOCK_W    = 8,
  parameter int INIT_STOCK = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  vend_change_dispenser_if.slave bus,
  input  logic                  refill_valid,
  input  logic [1:0]            refill_denom,
  input  logic [STOCK_W-1:0]    refill_count,
  output logic [STOCK_W-1:0]    stock1,
  output logic [STOCK_W-1:0]    stock5,
  output logic [STOCK_W-1:0]    stock10
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [15:0]           paid_total
`endif
);

  localparam logic [AMT_W-1:0] AMT_1  = AMT_W'(VAL_1);
  localparam logic [AMT_W-1:0] AMT_5  = AMT_W'(VAL_5);
  localparam logic [AMT_W-1:0] AMT_10 = AMT_W'(VAL_10);

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [AMT_W-1:0]   short_q, short_d;
  denom_t             denom_q, denom_d;
  logic               eject_valid_q, eject_valid_d;
  logic               done_q, done_d;
  logic               req_ready_q, req_ready_d;

  logic [STOCK_W-1:0] stock_cnt [NUM_DENOM];
  logic [NUM_DENOM-1:0] dec_en;
  logic [NUM_DENOM-1:0] refill_en;
  logic               eject_fire;
  logic               can_10, can_5, can_1;

  // An ack only counts while a coin is actually being offered.
  assign eject_fire = (state_q == EJECT) && bus.eject_ack;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DENOM; gi++) begin : g_stock
      assign dec_en[gi]    = eject_fire && (denom_q == denom_t'(gi));
      assign refill_en[gi] = refill_valid && (refill_denom == 2'(gi));

      coin_stock_ctr #(
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
      ) u_ctr (
        .clk          (clk),
        .rst          (rst),
        .refill_en    (refill_en[gi]),
        .refill_count (refill_count),
        .dec_en       (dec_en[gi]),
        .stock        (stock_cnt[gi])
      );
    end
  endgenerate

  assign can_10 = (remaining_q >= AMT_10) && (stock_cnt[DEN_10] != '0);
  assign can_5  = (remaining_q >= AMT_5)  && (stock_cnt[DEN_5]  != '0);
  assign can_1  = (remaining_q >= AMT_1)  && (stock_cnt[DEN_1]  != '0);

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    short_d       = short_q;
    denom_d       = denom_q;
    eject_valid_d = eject_valid_q;
    done_d        = 1'b0;
    req_ready_d   = req_ready_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          remaining_d = bus.req_amount;
          short_d     = '0;
          req_ready_d = 1'b0;
          state_d     = SELECT;
        end
      end

      SELECT: begin
        if (can_10) begin
          denom_d       = DEN_10;
          eject_valid_d = 1'b1;
          state_d       = EJECT;
        end else if (can_5) begin
          denom_d       = DEN_5;
          eject_valid_d = 1'b1;
          state_d       = EJECT;
        end else if (can_1) begin
          denom_d       = DEN_1;
          eject_valid_d = 1'b1;
          state_d       = EJECT;
        end else begin
          // Covers both "fully paid" (remaining is 0) and "no coin fits":
          // the shortfall is simply whatever is left.
          short_d = remaining_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      EJECT: begin
        // denom_q stays frozen here, so a concurrent refill cannot
        // change the coin already offered to the hopper.
        if (bus.eject_ack) begin
          remaining_d   = remaining_q - AMT_W'(coin_value(denom_q));
          eject_valid_d = 1'b0;
          state_d       = SELECT;
        end
      end

      DONE: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        eject_valid_d = 1'b0;
        req_ready_d   = 1'b1;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      short_q       <= '0;
      denom_q       <= DEN_1;
      eject_valid_q <= 1'b0;
      done_q        <= 1'b0;
      req_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      short_q       <= short_d;
      denom_q       <= denom_d;
      eject_valid_q <= eject_valid_d;
      done_q        <= done_d;
      req_ready_q   <= req_ready_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.eject_valid = eject_valid_q;
  assign bus.eject_denom = denom_q;
  assign bus.done        = done_q;
  assign bus.short_amt   = short_q;

  assign stock1  = stock_cnt[DEN_1];
  assign stock5  = stock_cnt[DEN_5];
  assign stock10 = stock_cnt[DEN_10];

`ifdef CHANGE_AUDIT_EN
  logic [15:0] paid_total_q, paid_total_d;

  always_comb begin
    paid_total_d = paid_total_q;
    if (eject_fire) begin
      paid_total_d = paid_total_q + 16'(coin_value(denom_q));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paid_total_q <= '0;
    end else begin
      paid_total_q <= paid_total_d;
    end
  end

  assign paid_total = paid_total_q;
`endif

endmodule
